// File: rtl/rr_mux2.sv
// ---------------------------------------------------------------------------
// rr_mux2 : two-input round-robin stream multiplexer with a one-entry
//           registered output stage.
//
// Merges two valid/ready streams (A, B) onto one output stream and tags each
// output word with the index of the source it came from.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   a_data   in   source A word            (WIDTH)
//   a_valid  in   source A word present
//   a_ready  out  source A word accepted when a_valid & a_ready (comb)
//   b_data   in   source B word            (WIDTH)
//   b_valid  in   source B word present
//   b_ready  out  source B word accepted when b_valid & b_ready (comb)
//   y_data   out  registered output word   (WIDTH)
//   y_valid  out  registered output word present
//   y_sel    out  source of y_data: 0 = A, 1 = B
//   y_ready  in   downstream accepts y_data when y_valid & y_ready
// ---------------------------------------------------------------------------
module rr_mux2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_sel,
  input  logic             y_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             r_last_sel;

  logic             w_load_en;
  logic             w_a_turn;
  logic             w_b_turn;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_grant;
  logic             w_grant_sel;
  logic [WIDTH-1:0] w_grant_data;

  // Output register can take a word when empty or being drained this cycle.
  assign w_load_en = (r_state == ST_EMPTY) | y_ready;

  // A source may go if the other is idle or the other was granted last.
  // These terms never look at the source's own valid, so ready stays
  // independent of its own valid.
  assign w_a_turn = ~b_valid | (r_last_sel == SEL_B);
  assign w_b_turn = ~a_valid | (r_last_sel == SEL_A);

  assign w_grant_a    = a_valid & w_a_turn;
  assign w_grant_b    = b_valid & w_b_turn;
  assign w_grant      = w_grant_a | w_grant_b;
  assign w_grant_sel  = w_grant_b ? SEL_B : SEL_A;
  assign w_grant_data = w_grant_b ? b_data : a_data;

  // During reset both readies read high; the register ignores them anyway.
  assign a_ready = rst | (w_load_en & w_a_turn);
  assign b_ready = rst | (w_load_en & w_b_turn);

  // Output stage state machine: data, tag and priority update on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_data     <= '0;
      r_sel      <= SEL_A;
      r_last_sel <= SEL_B;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_grant) begin
            r_state    <= ST_FULL;
            r_data     <= w_grant_data;
            r_sel      <= w_grant_sel;
            r_last_sel <= w_grant_sel;
          end
        end
        ST_FULL: begin
          // Stalled when y_ready is low: everything holds.
          if (y_ready) begin
            if (w_grant) begin
              r_data     <= w_grant_data;
              r_sel      <= w_grant_sel;
              r_last_sel <= w_grant_sel;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign y_valid = (r_state == ST_FULL);
  assign y_data  = r_data;
  assign y_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux2.sv
// ---------------------------------------------------------------------------
// tb_rr_mux2 : self-checking bench for rr_mux2 with a behavioural model of
// the output slot, per-source scoreboards and directed literal checks.
// ---------------------------------------------------------------------------
module tb_rr_mux2;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_sel;
  logic             y_ready;

  rr_mux2 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_sel   (y_sel),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the output slot holds and who was served last.
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  bit               m_sel;
  bit               m_last;
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  // Observed handshakes of the current cycle and last source served by DUT.
  bit hs_a;
  bit hs_b;
  bit dut_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_sel    = 1'b0;
    m_last   = 1'b1;
    dut_last = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  // Compare at the falling edge: model vs DUT, scoreboard, fairness.
  task automatic sample();
    bit space;
    bit exp_a;
    bit exp_b;
    @(negedge clk);
    space = !m_valid || y_ready;
    // A source is let through when there is room and the rival is either
    // silent or was the one served last time.
    exp_a = space && (b_valid ? (m_last == 1'b1) : 1'b1);
    exp_b = space && (a_valid ? (m_last == 1'b0) : 1'b1);
    chk("y_valid", 32'(y_valid), 32'(m_valid));
    if (m_valid) begin
      chk("y_data", 32'(y_data), 32'(m_data));
      chk("y_sel", 32'(y_sel), 32'(m_sel));
    end
    chk("a_ready", 32'(a_ready), 32'(exp_a));
    chk("b_ready", 32'(b_ready), 32'(exp_b));
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    chk("one_grant", 32'(hs_a && hs_b), 32'd0);
    // Contention must alternate: the winner is never the last one served.
    if (a_valid && b_valid && (hs_a || hs_b))
      chk("contend_alt", 32'(hs_b), 32'(!dut_last));
    if (hs_b) dut_last = 1'b1;
    else if (hs_a) dut_last = 1'b0;
    // Word leaving the output must be the oldest outstanding one of its source.
    if (y_valid && y_ready) begin
      if (y_sel) begin
        if (qb.size() == 0) chk("sb_b_empty", 32'(qb.size()), 32'd1);
        else chk("sb_b_order", 32'(y_data), 32'(qb.pop_front()));
      end else begin
        if (qa.size() == 0) chk("sb_a_empty", 32'(qa.size()), 32'd1);
        else chk("sb_a_order", 32'(y_data), 32'(qa.pop_front()));
      end
    end
  endtask

  // Rising edge: advance the model from the stable inputs, then step off it.
  task automatic edge_step();
    bit space;
    int win;
    @(posedge clk);
    if (!rst) begin
      space = !m_valid || y_ready;
      if (a_valid && b_valid) win = m_last ? 0 : 1;
      else if (a_valid)       win = 0;
      else if (b_valid)       win = 1;
      else                    win = -1;
      if (space) begin
        if (win == 0) begin
          qa.push_back(a_data);
          m_valid = 1'b1; m_data = a_data; m_sel = 1'b0; m_last = 1'b0;
        end else if (win == 1) begin
          qb.push_back(b_data);
          m_valid = 1'b1; m_data = b_data; m_sel = 1'b1; m_last = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    y_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_c[6];
  int ia;
  int ib;

  initial begin
    exp_c = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
    do_reset();

    // Mid-cycle reset while FULL clears the output without a clock edge.
    a_valid = 1'b1; a_data = 8'h5A; y_ready = 1'b0;
    sample(); edge_step();
    sample();
    chk("pre_rst_data", 32'(y_data), 32'h5A);
    chk("pre_rst_valid", 32'(y_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(y_valid), 32'd0);
    chk("rst_data", 32'(y_data), 32'h00);
    chk("rst_sel", 32'(y_sel), 32'd0);
    b_valid = 1'b1;
    #1;
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    model_reset();
    edge_step();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    sample();
    chk("post_rst_valid", 32'(y_valid), 32'd0);
    edge_step();

    // Single source streams 01..04 with one-cycle latency.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      a_valid = (i < 4);
      a_data  = WIDTH'(i + 1);
      sample();
      if (i > 0) begin
        chk("single_data", 32'(y_data), 32'(i));
        chk("single_sel", 32'(y_sel), 32'd0);
      end
      edge_step();
    end
    sample(); edge_step();

    // Sustained contention alternates A, B, A, B starting with A.
    do_reset();
    ia = 0; ib = 0;
    for (int k = 0; k < 7; k++) begin
      a_valid = 1'b1; a_data = WIDTH'(8'hA0 + ia);
      b_valid = 1'b1; b_data = WIDTH'(8'hB0 + ib);
      sample();
      if (k > 0) begin
        chk("contend_data", 32'(y_data), 32'(exp_c[k-1]));
        chk("contend_sel", 32'(y_sel), 32'((k - 1) % 2));
      end
      edge_step();
      if (hs_a) ia++;
      if (hs_b) ib++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    sample(); edge_step();

    // Backpressure: B3 held for three stalled cycles, then A loads at once.
    do_reset();
    b_valid = 1'b1; b_data = 8'hB3;
    sample(); edge_step();
    y_ready = 1'b0;
    a_valid = 1'b1; a_data = 8'hC1;
    b_valid = 1'b1; b_data = 8'hB4;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("bp_data", 32'(y_data), 32'hB3);
      chk("bp_sel", 32'(y_sel), 32'd1);
      chk("bp_readys", 32'({a_ready, b_ready}), 32'd0);
      edge_step();
    end
    y_ready = 1'b1;
    sample(); edge_step();
    a_valid = 1'b0;
    sample();
    chk("bp_next_valid", 32'(y_valid), 32'd1);
    chk("bp_next_data", 32'(y_data), 32'hC1);
    chk("bp_next_sel", 32'(y_sel), 32'd0);
    edge_step();
    b_valid = 1'b0;
    repeat (2) begin sample(); edge_step(); end

    // Drain to empty: one B word is visible for exactly one cycle.
    do_reset();
    b_valid = 1'b1; b_data = 8'h77;
    sample(); edge_step();
    b_valid = 1'b0;
    sample();
    chk("drain_valid", 32'(y_valid), 32'd1);
    chk("drain_data", 32'(y_data), 32'h77);
    chk("drain_sel", 32'(y_sel), 32'd1);
    edge_step();
    sample();
    chk("drain_empty", 32'(y_valid), 32'd0);
    edge_step();

    // Random soak: sources hold their word until it is accepted.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      sample();
      edge_step();
      if (hs_a || !a_valid) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = WIDTH'($urandom);
      end
      if (hs_b || !b_valid) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data  = WIDTH'($urandom);
      end
      y_ready = ($urandom_range(0, 9) < 7);
    end
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    repeat (3) begin sample(); edge_step(); end
    chk("sb_leftover", 32'(qa.size() + qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux2.md
# rr_mux2

Two-input, round-robin arbitrated stream multiplexer with a registered output stage. It merges two valid/ready data streams (source A, source B) into one output stream, tagging each output word with its source index. It is the combining counterpart of the gates-library 1:2 demux: where the demux steers one input to one of two outputs, this block steers one of two inputs onto a single output under flow control.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a_data  input  WIDTH  source A word
- a_valid  input  1  source A word present
- a_ready  output  1  source A word accepted this cycle when a_valid & a_ready
- b_data  input  WIDTH  source B word
- b_valid  input  1  source B word present
- b_ready  output  1  source B word accepted this cycle when b_valid & b_ready
- y_data  output  WIDTH  registered output word
- y_valid  output  1  registered output word present
- y_sel  output  1  source of current y_data: 0 = A, 1 = B
- y_ready  input  1  downstream accepts y_data when y_valid & y_ready

## Operation
- One clock domain. Reset is asynchronous and active-high; the clock and reset ports are clk and rst.
- Output stage is a one-entry register with two states:
  - EMPTY (y_valid=0)
  - FULL (y_valid=1)
- load_en = !y_valid | y_ready, meaning the register is empty or is being drained this cycle.
- Priority register last_sel (1 bit) holds the source granted most recently.
- Grant, combinational:
  - grant_a = a_valid & (!b_valid | last_sel==1)
  - grant_b = b_valid & (!a_valid | last_sel==0)
  - At most one of grant_a and grant_b is true.
- Ready outputs:
  - a_ready = load_en & (!b_valid | last_sel==1)
  - b_ready = load_en & (!a_valid | last_sel==0)
  - Each ready may depend combinationally on the other source's valid and on y_ready. It never depends on its own valid.
- On a clock edge with load_en & (grant_a | grant_b):
  - y_data <= granted data
  - y_sel <= granted index
  - y_valid <= 1
  - last_sel <= granted index
- On a clock edge with load_en and no grant: y_valid <= 0. y_data and y_sel hold their previous values.
- When !load_en (FULL and stalled): y_data, y_sel, y_valid and last_sel all hold. Both readys are 0.
- Arbitration outcomes:
  - Single requester is always served, regardless of last_sel (no idle cycles).
  - Both requesting: the source other than last_sel wins, so sustained contention strictly alternates A, B, A, B…
- No data is dropped or duplicated. Every accepted input word appears on the output exactly once, in per-source order.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on (y_ready & grant) or on !y_ready.
  - FULL→EMPTY on y_ready & no grant.

## Timing
- Reset values: y_valid=0, y_data=0, y_sel=0, last_sel=1 (A wins the first contention). With rst high, a_ready = b_ready = 1 combinationally, but nothing is captured.
- Latency: a word accepted at edge N is visible on y_data/y_valid after edge N.
- Throughput: 1 word/cycle while y_ready=1.
- Simultaneous drain and load: the new word replaces the drained word on the same edge with no bubble.
- Backpressure: while y_ready=0 and FULL, inputs must hold their words. Upstream keeps a_valid/a_data stable until accepted.
- Reset mid-operation: rst assertion immediately (asynchronously) clears y_valid, y_data, y_sel and sets last_sel=1. Any word held in the output register is discarded. Operation resumes on the first edge after rst deassertion.
- y_data/y_sel are don't-care when y_valid=0; the bench compares them only when y_valid=1.

## Test plan
- Reset: assert rst mid-cycle with register FULL (y_data=8'h5A) -> y_valid=0, y_data=8'h00, y_sel=0 immediately, without waiting for a clock edge.
- Single source: a_valid=1 with words 8'h01..8'h04, b_valid=0, y_ready=1 -> y_data=01,02,03,04 on four consecutive cycles, y_sel=0, one cycle latency.
- Contention: a_valid=b_valid=1 continuously (A: 8'hA0.., B: 8'hB0..), y_ready=1 -> output A0,B0,A1,B1,A2,B2 with y_sel=0,1,0,1,0,1.
- Backpressure: hold y_ready=0 for 3 cycles with y_data=8'hB3 FULL -> y_data/y_sel stable, a_ready=b_ready=0. On y_ready=1, the next word loads with no gap.
- Drain to empty: one B word 8'h77 then both valids low, y_ready=1 -> y_valid high exactly 1 cycle with y_data=77, y_sel=1, then y_valid=0.
- Random soak: random valids and y_ready over 2000 cycles -> scoreboard per source shows no loss, duplication or reorder, and no source starves beyond 1 cycle under contention.
